// File: rtl/lsu_mem_adapter_if.sv
// lsu_mem_adapter_if: core request/response and data-memory port signals of the load/store adapter
interface lsu_mem_adapter_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_data;
   logic [1:0]        req_fcn;
   logic [2:0]        req_typ;
   logic              res_valid;
   logic [XLEN-1:0]   res_data;
   logic              err_misaligned;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN/8-1:0] mem_wstrb;
   logic              mem_we;
   logic              mem_res_valid;
   logic [XLEN-1:0]   mem_res_data;
   modport slave (
      input  req_valid, req_addr, req_data, req_fcn, req_typ, mem_req_ready, mem_res_valid, mem_res_data,
      output req_ready, res_valid, res_data, err_misaligned, mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_we
   );
   modport master (
      output req_valid, req_addr, req_data, req_fcn, req_typ, mem_req_ready, mem_res_valid, mem_res_data,
      input  req_ready, res_valid, res_data, err_misaligned, mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_we
   );
endinterface

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: aligns loads/stores between the memory stage and a word-wide dmem port
// typ encoding B=0 BU=1 H=2 HU=3 W=4 WU=5 X=6; fcn encoding RD=0 WR=1 X=2
module lsu_mem_adapter #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 2
) (
   input logic              clk,
   input logic              reset,
   lsu_mem_adapter_if.slave bus
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic              w_read, w_write, w_illegal, w_mis, w_ready, w_acc, w_ok, w_push, w_pop;
   logic [1:0]        w_size;
   logic [OW-1:0]     w_off;
   logic [NB-1:0]     w_mask;
   logic [XLEN-1:0]   w_wdata, w_shift, w_ext;
   logic [2:0]        w_htyp;
   logic              r_mem_req_valid, r_mem_we, r_res_valid, r_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [XLEN-1:0]   r_mem_wdata, r_res_data;
   logic [NB-1:0]     r_mem_wstrb;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_wp, r_rp;
   logic [OW-1:0]     r_tag_off [DEPTH];
   logic [2:0]        r_tag_typ [DEPTH];

   always_comb begin
      w_read    = bus.req_fcn == 2'd0;
      w_write   = bus.req_fcn == 2'd1;
      w_size    = bus.req_typ < 3'd2 ? 2'd0 : bus.req_typ < 3'd4 ? 2'd1 : 2'd2;
      w_off     = bus.req_addr[OW-1:0];
      w_illegal = !(w_read || w_write) || bus.req_typ > 3'd5 || (bus.req_typ == 3'd5 && XLEN == 32);
      w_mis     = (w_size == 2'd1 && w_off[0]) || (w_size == 2'd2 && w_off[1:0] != 2'd0);
      w_ok      = !w_illegal && !w_mis;
      // a full tag FIFO stalls loads regardless of a same-cycle response
      w_ready   = (!r_mem_req_valid || bus.mem_req_ready) && !(w_read && r_cnt == CW'(DEPTH));
      w_acc     = bus.req_valid && w_ready;
      w_push    = w_acc && w_ok && w_read;
      w_pop     = bus.mem_res_valid && r_cnt != '0;
      w_wdata   = w_size == 2'd0 ? {NB{bus.req_data[7:0]}} :
                  w_size == 2'd1 ? {(NB/2){bus.req_data[15:0]}} : {(NB/4){bus.req_data[31:0]}};
      w_mask    = w_size == 2'd0 ? NB'(1) : w_size == 2'd1 ? NB'(3) : NB'(15);
      w_htyp    = r_tag_typ[r_rp];
      w_shift   = bus.mem_res_data >> {r_tag_off[r_rp], 3'b000};
      w_ext     = w_htyp == 3'd0 ? XLEN'($signed(w_shift[7:0])) :
                  w_htyp == 3'd1 ? XLEN'(w_shift[7:0]) :
                  w_htyp == 3'd2 ? XLEN'($signed(w_shift[15:0])) :
                  w_htyp == 3'd3 ? XLEN'(w_shift[15:0]) :
                  w_htyp == 3'd4 ? XLEN'($signed(w_shift[31:0])) : XLEN'(w_shift[31:0]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_mem_wstrb     <= '0;
         r_mem_we        <= 1'b0;
         r_err           <= 1'b0;
         r_res_valid     <= 1'b0;
         r_res_data      <= '0;
         r_cnt           <= '0;
         r_wp            <= '0;
         r_rp            <= '0;
      end else begin
         r_err       <= w_acc && !w_ok;
         r_res_valid <= w_pop;
         r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (w_acc) begin
            r_mem_req_valid <= w_ok;
            if (w_ok) begin
               r_mem_addr  <= {bus.req_addr[ADDR_W-1:OW], OW'(0)};
               r_mem_wdata <= w_wdata;
               r_mem_wstrb <= w_write ? w_mask << w_off : '0;
               r_mem_we    <= w_write;
            end
         end else if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
         end
         if (w_push)
            r_wp <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
         if (w_pop) begin
            r_rp       <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
            r_res_data <= w_ext;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tag_off[r_wp] <= w_off;
         r_tag_typ[r_wp] <= bus.req_typ;
      end
   end

   assign bus.req_ready      = w_ready;
   assign bus.mem_req_valid  = r_mem_req_valid;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_wdata      = r_mem_wdata;
   assign bus.mem_wstrb      = r_mem_wstrb;
   assign bus.mem_we         = r_mem_we;
   assign bus.err_misaligned = r_err;
   assign bus.res_valid      = r_res_valid;
   assign bus.res_data       = r_res_data;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb_lsu_mem_adapter: directed vectors with hand-computed expectations for lsu_mem_adapter
module tb_lsu_mem_adapter;
   localparam logic [1:0] LD = 2'd0, ST = 2'd1, FX = 2'd2;
   localparam logic [2:0] MB = 3'd0, MHU = 3'd3, MH = 3'd2, MW = 3'd4, MWU = 3'd5, MX = 3'd6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_err = 0;

   lsu_mem_adapter_if #(.XLEN(32), .ADDR_W(32)) bus ();
   lsu_mem_adapter #(.XLEN(32), .ADDR_W(32), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      bus.req_valid = 1'b1;
      bus.req_fcn   = f;
      bus.req_typ   = t;
      bus.req_addr  = a;
      bus.req_data  = d;
   endtask

   initial begin
      bus.req_valid = 0; bus.req_addr = 0; bus.req_data = 0; bus.req_fcn = 0; bus.req_typ = 0;
      bus.mem_req_ready = 1; bus.mem_res_valid = 0; bus.mem_res_data = 0;
      repeat (2) tick;
      chk("rst_mvalid", bus.mem_req_valid, 0);
      chk("rst_maddr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_wstrb", bus.mem_wstrb, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_rvalid", bus.res_valid, 0);
      chk("rst_rdata", bus.res_data, 0);
      chk("rst_err", bus.err_misaligned, 0);
      reset = 0;
      tick;
      // LB sign-extended from the top byte
      req(LD, MB, 32'h103, 0);
      #1 chk("lb_ready", bus.req_ready, 1);
      tick;
      bus.req_valid = 0;
      chk("lb_mvalid", bus.mem_req_valid, 1);
      chk("lb_maddr", bus.mem_addr, 32'h100);
      chk("lb_wstrb", bus.mem_wstrb, 0);
      chk("lb_we", bus.mem_we, 0);
      bus.mem_res_valid = 1; bus.mem_res_data = 32'h80FF_0000;
      tick;
      bus.mem_res_valid = 0;
      chk("lb_issued", bus.mem_req_valid, 0);
      chk("lb_rvalid", bus.res_valid, 1);
      chk("lb_rdata", bus.res_data, 32'hFFFF_FF80);
      tick;
      chk("lb_pulse", bus.res_valid, 0);
      chk("lb_hold", bus.res_data, 32'hFFFF_FF80);
      // LHU zero-extended from the upper half
      req(LD, MHU, 32'h102, 0);
      tick;
      bus.req_valid = 0;
      bus.mem_res_valid = 1; bus.mem_res_data = 32'h8001_0000;
      tick;
      bus.mem_res_valid = 0;
      chk("lhu_rdata", bus.res_data, 32'h0000_8001);
      // SH formatting
      req(ST, MH, 32'h102, 32'h1234_ABCD);
      tick;
      bus.req_valid = 0;
      chk("sh_mvalid", bus.mem_req_valid, 1);
      chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
      chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
      chk("sh_we", bus.mem_we, 1);
      tick;
      chk("sh_done", bus.mem_req_valid, 0);
      // misaligned and illegal requests
      req(LD, MW, 32'h101, 0);
      tick;
      bus.req_valid = 0;
      chk("lw_mis_mvalid", bus.mem_req_valid, 0);
      chk("lw_mis_err", bus.err_misaligned, 1);
      tick;
      chk("lw_mis_pulse", bus.err_misaligned, 0);
      req(LD, MX, 32'h100, 0);
      tick;
      bus.req_valid = 0;
      chk("mtx_err", bus.err_misaligned, 1);
      chk("mtx_mvalid", bus.mem_req_valid, 0);
      req(LD, MWU, 32'h100, 0);
      tick;
      chk("wu_err", bus.err_misaligned, 1);
      req(FX, MW, 32'h100, 0);
      tick;
      bus.req_valid = 0;
      chk("mx_err", bus.err_misaligned, 1);
      chk("mx_mvalid", bus.mem_req_valid, 0);
      tick;
      chk("mx_pulse", bus.err_misaligned, 0);
      // three LWs against a two-deep tag FIFO
      req(LD, MW, 32'h200, 0);
      #1 chk("q_rdy1", bus.req_ready, 1);
      tick;
      bus.req_addr = 32'h204;
      #1 chk("q_rdy2", bus.req_ready, 1);
      tick;
      bus.req_addr = 32'h208;
      #1 chk("q_full", bus.req_ready, 0);
      tick;
      chk("q_noissue", bus.mem_req_valid, 0);
      bus.mem_res_valid = 1; bus.mem_res_data = 32'h1;
      #1 chk("q_nocomb", bus.req_ready, 0);
      tick;
      bus.mem_res_valid = 0;
      chk("q_r1_valid", bus.res_valid, 1);
      chk("q_r1_data", bus.res_data, 32'h1);
      chk("q_rdy3", bus.req_ready, 1);
      tick;
      bus.req_valid = 0;
      chk("q_m3_addr", bus.mem_addr, 32'h208);
      chk("q_m3_valid", bus.mem_req_valid, 1);
      bus.mem_res_valid = 1; bus.mem_res_data = 32'h2;
      tick;
      chk("q_r2_data", bus.res_data, 32'h2);
      bus.mem_res_data = 32'h33;
      tick;
      bus.mem_res_valid = 0;
      chk("q_r3_data", bus.res_data, 32'h33);
      tick;
      // store held by mem_req_ready=0
      bus.mem_req_ready = 0;
      req(ST, MW, 32'h300, 32'hDEAD_BEEF);
      tick;
      req(ST, MB, 32'h305, 32'h77);
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready", bus.req_ready, 0);
         chk("bp_mvalid", bus.mem_req_valid, 1);
         chk("bp_addr", bus.mem_addr, 32'h300);
         chk("bp_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         chk("bp_wstrb", bus.mem_wstrb, 4'hF);
         tick;
      end
      bus.mem_req_ready = 1;
      #1 chk("bp_release", bus.req_ready, 1);
      tick;
      bus.req_valid = 0;
      chk("sb_addr", bus.mem_addr, 32'h304);
      chk("sb_wdata", bus.mem_wdata, 32'h7777_7777);
      chk("sb_wstrb", bus.mem_wstrb, 4'b0010);
      tick;
      chk("sb_done", bus.mem_req_valid, 0);
      // reset with two loads outstanding, then a stale response
      req(LD, MW, 32'h400, 0);
      tick;
      bus.req_addr = 32'h404;
      tick;
      bus.req_valid = 0;
      tick;
      #2 reset = 1;
      #1 chk("ar_mvalid", bus.mem_req_valid, 0);
      chk("ar_rdata", bus.res_data, 0);
      tick;
      reset = 0;
      bus.mem_res_valid = 1; bus.mem_res_data = 32'h55;
      tick;
      bus.mem_res_valid = 0;
      chk("stale_rvalid", bus.res_valid, 0);
      chk("stale_rdata", bus.res_data, 0);
      req(LD, MW, 32'h500, 0);
      #1 chk("ar_rdy1", bus.req_ready, 1);
      tick;
      bus.req_addr = 32'h504;
      #1 chk("ar_rdy2", bus.req_ready, 1);
      tick;
      bus.req_addr = 32'h508;
      #1 chk("ar_full", bus.req_ready, 0);
      bus.req_valid = 0;
      bus.mem_res_valid = 1; bus.mem_res_data = 32'hAA;
      tick;
      chk("ar_r1", bus.res_data, 32'hAA);
      bus.mem_res_data = 32'hBB;
      tick;
      bus.mem_res_valid = 0;
      chk("ar_r2", bus.res_data, 32'hBB);
      tick;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
